inst_fetch: RTL and testbench

Instruction fetch stage between the PC/branch-prediction stage and decode. Each cycle it takes the predicted PC and prediction metadata, issues an in-order read to the instruction ROM/cache port, and buffers outstanding fetches in a small queue. The queue pairs each returned instruction word with its PC and prediction info and hands it to decode over a valid/ready handshake. It back-pressures the PC stage via `stall_out` and discards stale responses after a flush.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch_queue.sv | 116 +++++++++++
 rtl/inst_fetch.sv | 118 +++++++++++
 tb/tb_inst_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants and default widths.
// INVALID_PC marks an empty PC slot that is never fetched.
package inst_fetch_pkg;

    localparam int DEF_QUEUE_DEPTH = 4;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int GHR_WIDTH       = 5;

    localparam logic [31:0] INVALID_PC = 32'h0000_0000;
    localparam logic [31:0] INIT_PC    = 32'hBFC0_0000;

    typedef logic [DEF_ADDR_WIDTH-1:0] ADDR_BUS;
    typedef logic [DEF_DATA_WIDTH-1:0] DATA_BUS;
    typedef logic [GHR_WIDTH-1:0]      GHR_BUS;

endpackage

// File: rtl/inst_fetch_queue.sv
// Fetch queue: entries are allocated in issue order at tail, filled in order
// at fill_ptr as ROM words return, and popped from head once filled.
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int GHR_WIDTH   = inst_fetch_pkg::GHR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_en,
    input  logic [ADDR_WIDTH-1:0] alloc_pc,
    input  logic                  alloc_taken,
    input  logic [GHR_WIDTH-1:0]  alloc_pht,
    input  logic                  fill_en,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  pop_en,
    output logic                  full,
    output logic                  head_filled,
    output logic                  head_at_fill,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_taken,
    output logic [GHR_WIDTH-1:0]  head_pht
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]  pc_q    [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_d    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]  data_q  [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]  data_d  [QUEUE_DEPTH];
    logic [GHR_WIDTH-1:0]   pht_q   [QUEUE_DEPTH];
    logic [GHR_WIDTH-1:0]   pht_d   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] taken_q, taken_d;
    logic [QUEUE_DEPTH-1:0] filled_q, filled_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [PTR_W-1:0]       fill_q, fill_d;
    logic [OCC_W-1:0]       occ_q, occ_d;

    always_comb begin
        pc_d     = pc_q;
        data_d   = data_q;
        pht_d    = pht_q;
        taken_d  = taken_q;
        filled_d = filled_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fill_d   = fill_q;
        occ_d    = occ_q;
        if (flush) begin
            filled_d = '0;
            head_d   = '0;
            tail_d   = '0;
            fill_d   = '0;
            occ_d    = '0;
        end else begin
            if (alloc_en) begin
                pc_d[tail_q]     = alloc_pc;
                pht_d[tail_q]    = alloc_pht;
                taken_d[tail_q]  = alloc_taken;
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + PTR_W'(1);
            end
            if (pop_en) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PTR_W'(1);
            end
            // A word bypassed straight to decode leaves its slot unfilled.
            if (fill_en) begin
                data_d[fill_q] = fill_data;
                if (!(pop_en && (fill_q == head_q)))
                    filled_d[fill_q] = 1'b1;
                fill_d = fill_q + PTR_W'(1);
            end
            occ_d = occ_q + OCC_W'(alloc_en) - OCC_W'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            occ_q    <= '0;
        end else begin
            filled_q <= filled_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fill_q   <= fill_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        data_q  <= data_d;
        pht_q   <= pht_d;
        taken_q <= taken_d;
    end

    assign full         = (occ_q == OCC_W'(QUEUE_DEPTH));
    assign head_filled  = filled_q[head_q];
    assign head_at_fill = (head_q == fill_q) && (occ_q != '0);
    assign head_pc      = pc_q[head_q];
    assign head_data    = data_q[head_q];
    assign head_taken   = taken_q[head_q];
    assign head_pht     = pht_q[head_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues in-order ROM reads, queues them, drops stale
// responses after a flush. Optional FETCH_BYPASS_EN forwards a returning word.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int GHR_WIDTH   = inst_fetch_pkg::GHR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  is_branch_taken_in,
    input  logic [GHR_WIDTH-1:0]  pht_index_in,
    output logic                  stall_out,
    output logic                  rom_req_valid,
    output logic [ADDR_WIDTH-1:0] rom_req_addr,
    input  logic                  rom_req_ready,
    input  logic                  rom_resp_valid,
    input  logic [DATA_WIDTH-1:0] rom_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  inst_taken,
    output logic [GHR_WIDTH-1:0]  inst_pht_index
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 2;
    localparam logic [ADDR_WIDTH-1:0] INV_PC = ADDR_WIDTH'(INVALID_PC);

    logic             pc_valid, alloc, issue, resp_keep, pop;
    logic             q_full, head_filled, head_at_fill;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pc_valid      = (pc_in != INV_PC) && !flush;
        alloc         = !q_full;
        rom_req_valid = pc_valid && alloc;
        rom_req_addr  = pc_in;
        stall_out     = pc_valid && !(alloc && rom_req_ready);
        issue         = rom_req_valid && rom_req_ready;
        resp_keep     = rom_resp_valid && (drop_cnt_q == '0) && !flush;
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;
    always_comb begin
        bypass     = resp_keep && !head_filled && head_at_fill;
        inst_valid = head_filled || bypass;
        inst_data  = bypass ? rom_resp_data : head_data;
    end
`else
    logic unused_head_at_fill;
    always_comb begin
        unused_head_at_fill = head_at_fill;
        inst_valid          = head_filled;
        inst_data           = head_data;
    end
`endif

    assign pop = inst_valid && inst_ready && !flush;

    // out_cnt tracks kept requests still in flight; on flush they all move
    // into drop_cnt, less any response landing in the flush cycle itself.
    always_comb begin
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            out_cnt_d  = '0;
            drop_cnt_d = drop_cnt_q + out_cnt_q - CNT_W'(rom_resp_valid);
        end else begin
            if (rom_resp_valid && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            out_cnt_d = out_cnt_q + CNT_W'(issue) - CNT_W'(resp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .GHR_WIDTH  (GHR_WIDTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_en    (issue),
        .alloc_pc    (pc_in),
        .alloc_taken (is_branch_taken_in),
        .alloc_pht   (pht_index_in),
        .fill_en     (resp_keep),
        .fill_data   (rom_resp_data),
        .pop_en      (pop),
        .full        (q_full),
        .head_filled (head_filled),
        .head_at_fill(head_at_fill),
        .head_pc     (inst_pc),
        .head_data   (head_data),
        .head_taken  (inst_taken),
        .head_pht    (inst_pht_index)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch (default build): ROM model answers in order
// with one cycle latency unless rom_hold withholds responses.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] pc_in;
    logic        is_branch_taken_in;
    logic [4:0]  pht_index_in;
    logic        stall_out;
    logic        rom_req_valid;
    logic [31:0] rom_req_addr;
    logic        rom_req_ready;
    logic        rom_resp_valid;
    logic [31:0] rom_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_taken;
    logic [4:0]  inst_pht_index;

    int errors = 0;
    int checks = 0;

    logic        rom_hold = 1'b0;
    logic [31:0] rom_q[$];
    logic        rom_fire, rom_took, rom_rst_s;
    logic [31:0] rom_faddr;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .pc_in             (pc_in),
        .is_branch_taken_in(is_branch_taken_in),
        .pht_index_in      (pht_index_in),
        .stall_out         (stall_out),
        .rom_req_valid     (rom_req_valid),
        .rom_req_addr      (rom_req_addr),
        .rom_req_ready     (rom_req_ready),
        .rom_resp_valid    (rom_resp_valid),
        .rom_resp_data     (rom_resp_data),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst_pc           (inst_pc),
        .inst_data         (inst_data),
        .inst_taken        (inst_taken),
        .inst_pht_index    (inst_pht_index)
    );

    // ROM: word at address A is ~A; answers in order, one cycle after accept.
    initial begin
        rom_resp_valid = 1'b0;
        rom_resp_data  = '0;
        forever begin
            @(negedge clk);
            rom_fire  = rom_req_valid && rom_req_ready;
            rom_faddr = rom_req_addr;
            rom_took  = rom_resp_valid;
            rom_rst_s = rst;
            @(posedge clk);
            #2;
            if (!rom_rst_s) rom_q.delete();
            else begin
                if (rom_took) void'(rom_q.pop_front());
                if (rom_fire) rom_q.push_back(rom_faddr);
            end
            if (rom_q.size() > 0 && !rom_hold) begin
                rom_resp_valid = 1'b1;
                rom_resp_data  = ~rom_q[0];
            end else begin
                rom_resp_valid = 1'b0;
                rom_resp_data  = '0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; pc_in = 32'h0; is_branch_taken_in = 1'b0;
        pht_index_in = '0; rom_req_ready = 1'b1; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (rom_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b exp 0", rom_req_valid); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall_out); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b exp 0", inst_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [6] = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 0, 0, 0};
        logic        tk  [6] = '{0, 1, 0, 0, 0, 0};
        logic [4:0]  ph  [6] = '{5'd1, 5'd3, 5'd7, 5'd0, 5'd0, 5'd0};
        logic        ev  [6] = '{0, 0, 1, 1, 1, 0};
        logic [31:0] epc [6] = '{0, 0, 32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 0};
        logic [31:0] edt [6] = '{0, 0, 32'h403FFFFF, 32'h403FFFFB, 32'h403FFFF7, 0};
        logic        etk [6] = '{0, 0, 0, 1, 0, 0};
        logic [4:0]  eph [6] = '{5'd0, 5'd0, 5'd1, 5'd3, 5'd7, 5'd0};
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pc_in = pcs[i]; is_branch_taken_in = tk[i]; pht_index_in = ph[i];
            @(negedge clk);
            if (i == 0) begin
                checks++; if (rom_req_valid !== 1'b1 || rom_req_addr !== 32'hBFC00000) begin errors++; $display("FAIL stream_req: got %b/%h exp 1/bfc00000", rom_req_valid, rom_req_addr); end
            end
            checks++; if (inst_valid !== ev[i]) begin errors++; $display("FAIL stream_valid[%0d]: got %b exp %b", i, inst_valid, ev[i]); end
            if (ev[i]) begin
                checks++;
                if (inst_pc !== epc[i] || inst_data !== edt[i] || inst_taken !== etk[i] || inst_pht_index !== eph[i]) begin
                    errors++;
                    $display("FAIL stream_entry[%0d]: got pc=%h data=%h tk=%b pht=%0d exp pc=%h data=%h tk=%b pht=%0d",
                             i, inst_pc, inst_data, inst_taken, inst_pht_index, epc[i], edt[i], etk[i], eph[i]);
                end
            end
        end
        is_branch_taken_in = 1'b0; pht_index_in = '0;
    endtask

    task automatic test_full();
        logic [31:0] pcs [8] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1010, 32'h1010, 32'h1010};
        logic        rdy [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        logic        est [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        logic        erv [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
        logic [31:0] epc [8] = '{0, 0, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
        logic [31:0] dpc [4] = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pc_in = pcs[i]; inst_ready = rdy[i];
            @(negedge clk);
            checks++; if (stall_out !== est[i]) begin errors++; $display("FAIL full_stall[%0d]: got %b exp %b", i, stall_out, est[i]); end
            checks++; if (rom_req_valid !== erv[i]) begin errors++; $display("FAIL full_req_valid[%0d]: got %b exp %b", i, rom_req_valid, erv[i]); end
            if (i >= 2) begin
                checks++; if (inst_valid !== 1'b1 || inst_pc !== epc[i]) begin errors++; $display("FAIL full_head[%0d]: got %b/%h exp 1/%h", i, inst_valid, inst_pc, epc[i]); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            pc_in = 32'h0; inst_ready = 1'b1;
            @(negedge clk);
            if (i < 4) begin
                checks++; if (inst_valid !== 1'b1 || inst_pc !== dpc[i] || inst_data !== ~dpc[i]) begin errors++; $display("FAIL full_drain[%0d]: got %b/%h/%h exp 1/%h/%h", i, inst_valid, inst_pc, inst_data, dpc[i], ~dpc[i]); end
            end else begin
                checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b exp 0", inst_valid); end
            end
        end
    endtask

    task automatic test_flush_inflight();
        logic [31:0] pcs [10] = '{32'h2000, 32'h2004, 32'h2008, 0, 32'h80000000, 0, 0, 0, 0, 0};
        logic        fl  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        logic        hd  [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        logic        erv [10] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        logic        ev  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            pc_in = pcs[i]; flush = fl[i]; rom_hold = hd[i];
            @(negedge clk);
            checks++; if (rom_req_valid !== erv[i]) begin errors++; $display("FAIL flush_req_valid[%0d]: got %b exp %b", i, rom_req_valid, erv[i]); end
            checks++; if (inst_valid !== ev[i]) begin errors++; $display("FAIL flush_valid[%0d]: got %b exp %b", i, inst_valid, ev[i]); end
            if (ev[i]) begin
                checks++; if (inst_pc !== 32'h80000000 || inst_data !== 32'h7FFFFFFF) begin errors++; $display("FAIL flush_new_entry: got %h/%h exp 80000000/7fffffff", inst_pc, inst_data); end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] pcs [8] = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h3004, 0, 0, 0};
        logic        rr  [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        logic        est [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        logic        erv [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic        ev  [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
        logic [31:0] epc [8] = '{0, 0, 0, 0, 0, 32'h3000, 32'h3004, 0};
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pc_in = pcs[i]; rom_req_ready = rr[i];
            @(negedge clk);
            checks++; if (stall_out !== est[i]) begin errors++; $display("FAIL bp_stall[%0d]: got %b exp %b", i, stall_out, est[i]); end
            checks++; if (rom_req_valid !== erv[i]) begin errors++; $display("FAIL bp_req_valid[%0d]: got %b exp %b", i, rom_req_valid, erv[i]); end
            checks++; if (inst_valid !== ev[i]) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp %b", i, inst_valid, ev[i]); end
            if (ev[i]) begin
                checks++; if (inst_pc !== epc[i] || inst_data !== ~epc[i]) begin errors++; $display("FAIL bp_entry[%0d]: got %h/%h exp %h/%h", i, inst_pc, inst_data, epc[i], ~epc[i]); end
            end
        end
    endtask

    task automatic test_flush_pop_resp();
        logic [31:0] pcs [10] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C, 0, 32'h5000, 0, 0, 0, 0};
        logic        hd  [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        logic        fl  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic        rdy [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic        ev  [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
        logic [31:0] epc [10] = '{0, 0, 32'h4000, 32'h4000, 32'h4000, 0, 0, 0, 32'h5000, 0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            pc_in = pcs[i]; rom_hold = hd[i]; flush = fl[i]; inst_ready = rdy[i];
            @(negedge clk);
            checks++; if (inst_valid !== ev[i]) begin errors++; $display("FAIL fpr_valid[%0d]: got %b exp %b", i, inst_valid, ev[i]); end
            if (ev[i]) begin
                checks++; if (inst_pc !== epc[i] || inst_data !== ~epc[i]) begin errors++; $display("FAIL fpr_entry[%0d]: got %h/%h exp %h/%h", i, inst_pc, inst_data, epc[i], ~epc[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_flush_inflight();
        test_back_pressure();
        test_flush_pop_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
